// File: rtl/sync_fifo_gen2.sv
// sync_fifo_gen2: single-clock FIFO with generic width/depth (non-power-of-2
// depth allowed), registered or first-word-fall-through read, programmable
// almost-full/almost-empty levels, synchronous flush and live occupancy.
module sync_fifo_gen2 #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            wr_en,
    input  logic [FIFO_WIDTH-1:0]           data_in,
    input  logic                            rd_en,
    output logic [FIFO_WIDTH-1:0]           data_out,
    output logic                            data_valid,
    output logic                            wr_ack,
    output logic                            overflow,
    output logic                            underflow,
    output logic                            full,
    output logic                            empty,
    output logic                            almostfull,
    output logic                            almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    // Reject configurations whose flag levels or geometry make no sense.
    if (FIFO_WIDTH < 1 || FIFO_DEPTH < 2 ||
        AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH - 1 ||
        AE_LEVEL < 1 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_param_err
        $error("sync_fifo_gen2: FIFO_WIDTH/FIFO_DEPTH/AF_LEVEL/AE_LEVEL out of range");
    end

    // Pointers wrap explicitly at the last entry so any depth works.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = PW'(0);
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  full_s, empty_s;
    logic                  wr_acc_s, rd_acc_s, mem_we_s;

    // Status flags are a pure decode of the current occupancy.
    always_comb begin
        full_s      = (count_q == DEPTH_C);
        empty_s     = (count_q == CW'(0));
        almostfull  = (count_q >= AF_C) && !full_s;
        almostempty = (count_q <= AE_C) && !empty_s;
        full        = full_s;
        empty       = empty_s;
        count       = count_q;
    end

    // Next-state computation: flush clears state, otherwise accept reads/writes.
    always_comb begin
        wr_acc_s     = wr_en && !full_s;
        rd_acc_s     = rd_en && !empty_s;
        mem_we_s     = 1'b0;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        wr_ack_d     = 1'b0;
        overflow_d   = 1'b0;
        underflow_d  = 1'b0;
        if (flush) begin
            wr_ptr_d = PW'(0);
            rd_ptr_d = PW'(0);
            count_d  = CW'(0);
        end else begin
            mem_we_s    = wr_acc_s && rst_n;
            wr_ack_d    = wr_acc_s;
            overflow_d  = wr_en && full_s;
            underflow_d = rd_en && empty_s;
            if (wr_acc_s) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d     = ptr_next(rd_ptr_q);
                data_out_d   = mem_q[rd_ptr_q];
                data_valid_d = 1'b1;
            end else begin
                rd_ptr_d     = rd_ptr_q;
                data_out_d   = data_out_q;
                data_valid_d = 1'b0;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= PW'(0);
            rd_ptr_q     <= PW'(0);
            count_q      <= CW'(0);
            data_out_q   <= FIFO_WIDTH'(0);
            data_valid_q <= 1'b0;
            wr_ack_q     <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            wr_ack_q     <= wr_ack_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage array; never cleared, only written on an accepted write.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Read port: registered word, or the head word shown directly in FWFT mode.
    always_comb begin
        wr_ack    = wr_ack_q;
        overflow  = overflow_q;
        underflow = underflow_q;
        if (FWFT != 0) begin
            data_valid = !empty_s;
            if (empty_s) begin
                data_out = data_out_q;
            end else begin
                data_out = mem_q[rd_ptr_q];
            end
        end else begin
            data_valid = data_valid_q;
            data_out   = data_out_q;
        end
    end

endmodule

// File: tb/tb_sync_fifo_gen2.sv
// Bench for sync_fifo_gen2: instance 0 is DEPTH=8 registered-read with default
// levels, instance 1 is DEPTH=5 FWFT with AF=3/AE=2. A queue-based reference
// model predicts flags and counts; a monitor checks read data from a scoreboard.
module tb_sync_fifo_gen2;

    typedef logic [15:0] word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  wr_v = 2'b00;
    logic [1:0]  rd_v = 2'b00;
    word_t       din_v [2];
    word_t       dout_v [2];
    logic [1:0]  dv_v, ack_v, ovf_v, udf_v, full_v, empty_v, af_v, ae_v;
    logic [3:0]  cnt0;
    logic [2:0]  cnt1;

    int          dep [2] = '{8, 5};
    int          afl [2] = '{7, 3};
    int          ael [2] = '{1, 2};

    word_t       mq [2][$];
    word_t       sbq [$];
    logic        e_ack [2];
    logic        e_ovf [2];
    logic        e_udf [2];
    logic        e_dv0 = 1'b0;
    word_t       e_dout0 = 16'h0000;

    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    sync_fifo_gen2 #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_v[0]), .data_in(din_v[0]),
        .rd_en(rd_v[0]), .data_out(dout_v[0]), .data_valid(dv_v[0]), .wr_ack(ack_v[0]),
        .overflow(ovf_v[0]), .underflow(udf_v[0]), .full(full_v[0]), .empty(empty_v[0]),
        .almostfull(af_v[0]), .almostempty(ae_v[0]), .count(cnt0)
    );

    sync_fifo_gen2 #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_v[1]), .data_in(din_v[1]),
        .rd_en(rd_v[1]), .data_out(dout_v[1]), .data_valid(dv_v[1]), .wr_ack(ack_v[1]),
        .overflow(ovf_v[1]), .underflow(udf_v[1]), .full(full_v[1]), .empty(empty_v[1]),
        .almostfull(af_v[1]), .almostempty(ae_v[1]), .count(cnt1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: one FIFO transaction per clock edge on a plain queue.
    task automatic model_upd(input int k, input logic rstn, input logic fl,
                             input logic w, input logic r, input word_t d);
        int    sz;
        word_t p;
        sz = mq[k].size();
        if (!rstn || fl) begin
            mq[k].delete();
            e_ack[k] = 1'b0;
            e_ovf[k] = 1'b0;
            e_udf[k] = 1'b0;
            if (k == 0) begin
                e_dv0 = 1'b0;
                sbq.delete();
                if (!rstn) e_dout0 = 16'h0000;
            end
        end else begin
            e_ack[k] = w && (sz != dep[k]);
            e_ovf[k] = w && (sz == dep[k]);
            e_udf[k] = r && (sz == 0);
            if (k == 0) e_dv0 = r && (sz != 0);
            if (r && sz != 0) begin
                p = mq[k].pop_front();
                if (k == 0) begin
                    sbq.push_back(p);
                    e_dout0 = p;
                end
            end
            if (w && sz != dep[k]) mq[k].push_back(d);
        end
    endtask

    task automatic check_outs(input int k);
        int    sz;
        string s;
        sz = mq[k].size();
        s  = $sformatf("d%0d", k);
        chk({s, ".count"}, (k == 0) ? 32'(cnt0) : 32'(cnt1), 32'(sz));
        chk({s, ".full"}, 32'(full_v[k]), 32'(sz == dep[k]));
        chk({s, ".empty"}, 32'(empty_v[k]), 32'(sz == 0));
        chk({s, ".almostfull"}, 32'(af_v[k]), 32'(sz >= afl[k] && sz != dep[k]));
        chk({s, ".almostempty"}, 32'(ae_v[k]), 32'(sz <= ael[k] && sz != 0));
        chk({s, ".wr_ack"}, 32'(ack_v[k]), 32'(e_ack[k]));
        chk({s, ".overflow"}, 32'(ovf_v[k]), 32'(e_ovf[k]));
        chk({s, ".underflow"}, 32'(udf_v[k]), 32'(e_udf[k]));
        if (k == 0) begin
            chk({s, ".data_valid"}, 32'(dv_v[0]), 32'(e_dv0));
            if (dv_v[0] !== 1'b1) chk({s, ".data_out_hold"}, 32'(dout_v[0]), 32'(e_dout0));
        end else begin
            chk({s, ".data_valid"}, 32'(dv_v[1]), 32'(sz != 0));
        end
    endtask

    // One clock of stimulus: drive, let the edge happen, advance model, check.
    task automatic step(input logic rstn, input logic fl, input logic [1:0] w,
                        input logic [1:0] r, input word_t d0, input word_t d1);
        rst_n    = rstn;
        flush    = fl;
        wr_v     = w;
        rd_v     = r;
        din_v[0] = d0;
        din_v[1] = d1;
        @(posedge clk);
        model_upd(0, rstn, fl, w[0], r[0], d0);
        model_upd(1, rstn, fl, w[1], r[1], d1);
        @(negedge clk);
        check_outs(0);
        check_outs(1);
    endtask

    // Monitor: whenever a DUT presents valid data, compare against the scoreboard.
    always @(negedge clk) begin
        if (dv_v[0] === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("d0.sb_has_word", 32'(sbq.size()), 32'd1);
            end else begin
                chk("d0.data_out", 32'(dout_v[0]), 32'(sbq.pop_front()));
            end
        end
        if (dv_v[1] === 1'b1 && mq[1].size() != 0) begin
            chk("d1.data_out", 32'(dout_v[1]), 32'(mq[1][0]));
        end
    end

    initial begin
        din_v[0] = 16'h0000;
        din_v[1] = 16'h0000;
        // Reset and check reset state.
        step(1'b0, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000);
        step(1'b0, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000);
        // Fill instance 0 with 1..8, then overflow with a 9th write.
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 2'b01, 2'b00, 16'(i), 16'h0000);
        step(1'b1, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000);
        // Drain with 8 reads plus one underflowing read.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 2'b00, 2'b01, 16'h0000, 16'h0000);
        step(1'b1, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000);
        // Simultaneous read/write at count 0, 4 and 8.
        step(1'b1, 1'b0, 2'b01, 2'b01, 16'h1111, 16'h0000);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b01, 2'b00, 16'(16'h2000 + i), 16'h0000);
        step(1'b1, 1'b0, 2'b01, 2'b01, 16'h3333, 16'h0000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'b01, 2'b00, 16'(16'h4000 + i), 16'h0000);
        step(1'b1, 1'b0, 2'b01, 2'b01, 16'h5555, 16'h0000);
        // Down to 6, then flush while writing.
        step(1'b1, 1'b0, 2'b00, 2'b01, 16'h0000, 16'h0000);
        step(1'b1, 1'b1, 2'b01, 2'b00, 16'h6666, 16'h0000);
        // Reset in the middle of a write burst.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b01, 2'b00, 16'(16'h7000 + i), 16'h0000);
        step(1'b0, 1'b0, 2'b01, 2'b01, 16'h7777, 16'h0000);
        step(1'b1, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000);
        // FWFT instance: word into empty FIFO shows up without a read, then pop it.
        step(1'b1, 1'b0, 2'b10, 2'b00, 16'h0000, 16'hABCD);
        step(1'b1, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000);
        step(1'b1, 1'b0, 2'b00, 2'b10, 16'h0000, 16'h0000);
        // Depth-5 wrap: 13 writes interleaved with reads, then drain.
        for (int i = 0; i < 13; i++)
            step(1'b1, 1'b0, 2'b10, (i % 3 == 2) ? 2'b10 : 2'b00, 16'h0000, 16'(16'hC000 + i));
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'b00, 2'b10, 16'h0000, 16'h0000);
        // Randomised traffic on both instances, with occasional flush/reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 2'($urandom), 2'($urandom),
                 16'($urandom), 16'($urandom));
        end
        step(1'b1, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
